regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file for the RISC-V core, with a per-register scoreboard (pending bits) and a post-reset clear sequencer. It sits in the decode stage. Decode reads two source operands with same-cycle write bypass. It also marks destination registers pending at issue. Writeback writes results and releases the pending marks. Register 0 is hardwired to zero, and the array is zeroed entry by entry after reset, so software never sees uninitialised contents.

## Interface
Parameters:
- XLEN, 32, data width in bits
- AW, 5, address width; NREG = 2**AW registers

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- src_add1  input  AW  read port 1 address
- src_add2  input  AW  read port 2 address
- datasent1  output  XLEN  read port 1 data (combinational)
- datasent2  output  XLEN  read port 2 data (combinational)
- busy1  output  1  register at src_add1 has an outstanding producer
- busy2  output  1  register at src_add2 has an outstanding producer
- write  input  1  writeback strobe
- write_add  input  AW  writeback address
- data_received  input  XLEN  writeback data
- issue  input  1  mark issue_add pending
- issue_add  input  AW  destination register of the issuing instruction
- ready  output  1  clear sequence finished; block accepts writes and issues

## Operation
- Two states: CLEAR and RUN. `rst` forces CLEAR, with the clear index at 0, and zeroes every pending bit.
- CLEAR behaviour:
  - Each cycle, `ram[idx]` <= 0 and idx increments.
  - When idx = NREG-1 is written, the next state is RUN.
  - `write` and `issue` are ignored.
  - `ready` = 0, datasent1/2 = 0, busy1/2 = 0.
- RUN behaviour:
  - `ready` = 1.
  - If `write` is high and write_add != 0, then `ram[write_add]` <= data_received and `pending[write_add]` <= 0.
  - If `issue` is high and issue_add != 0, then `pending[issue_add]` <= 1.
  - If `issue` and `write` target the same address in the same cycle, the set wins: pending stays 1, and the data is still written.
- Read path (RUN):
  - datasentN = 0 if src_addN = 0.
  - Otherwise, if write=1 and write_add = src_addN, datasentN = data_received (bypass).
  - Otherwise, datasentN = ram[src_addN].
- Busy path (RUN):
  - busyN = 0 if src_addN = 0.
  - Otherwise, busyN = pending[src_addN] with the same-cycle writeback applied: a matching write clears it, and a matching issue in that same cycle keeps it set.
  - An issue alone does not raise busy until the next cycle.
- Register 0: writes and issues to it are dropped. Its read value is 0 and its busy is 0 at all times.
- No arithmetic on the data. The clear index is AW+1 bits wide so the terminal count is unambiguous.

## Timing
- Reset values:
  - state = CLEAR, idx = 0, all pending = 0, ready = 0.
  - datasent1/2 = 0, busy1/2 = 0.
- Array contents are not reset directly; the clear sequence zeroes them.
- Clear duration: ready first goes high NREG cycles after the last cycle rst is high (32 cycles at default).
- `rst` asserted in CLEAR or RUN restarts from idx 0, and pending bits are cleared in the same cycle.
- Write latency:
  - visible on read ports in the same cycle via bypass;
  - visible from the array from the next rising edge.
- Issue latency: busy rises one cycle after issue.
- Writeback latency: busy falls in the same cycle as the write (combinational clear).
- Both read ports are independent. Identical addresses on both ports return identical data and busy.
- Write to an address that is not pending: data is written, and pending stays 0.

## Test plan
1. Clear sequence:
   - Stimulus: pulse rst for 1 cycle, then poll all 32 addresses with write=1 and data 0xFFFFFFFF held throughout CLEAR.
   - Required: ready=0 for exactly 32 cycles, then rises. All registers then read 0, showing the CLEAR-time writes were ignored.
2. Write then read:
   - Stimulus: in RUN, write x5=6 and x9=4, then read src_add1=5, src_add2=9.
   - Required: datasent1=6 and datasent2=4 on the cycle after the writes.
   - Stimulus: in the write cycle itself, read x5.
   - Required: datasent1=6 via bypass.
3. x0 immunity:
   - Stimulus: write x0=0xDEADBEEF and issue x0, then read x0 on both ports.
   - Required: datasent=0, busy=0.
4. Scoreboard:
   - Stimulus: issue x7 at cycle t.
   - Required: busy1 (src_add1=7) =1 from t+1 onward.
   - Stimulus: write x7=0x1234 at t+3.
   - Required: busy1=0 in cycle t+3; datasent1=0x1234 in t+3 and t+4.
5. Simultaneous issue and write:
   - Stimulus: issue x3 and write x3=0xA5 in the same cycle.
   - Required: the next cycle shows busy=1 for x3 and datasent=0xA5.
6. Reset mid-run:
   - Stimulus: x4 pending with value 9; assert rst for 1 cycle.
   - Required: ready=0 for 32 cycles, then x4 reads 0 with busy=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Decode-stage integer register file with write bypass, a per-register pending scoreboard
// and a post-reset sequencer that zeroes the array one entry per cycle.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   src_add1,
   input  logic [AW-1:0]   src_add2,
   output logic [XLEN-1:0] datasent1,
   output logic [XLEN-1:0] datasent2,
   output logic            busy1,
   output logic            busy2,
   input  logic            write,
   input  logic [AW-1:0]   write_add,
   input  logic [XLEN-1:0] data_received,
   input  logic            issue,
   input  logic [AW-1:0]   issue_add,
   output logic            ready
);

   localparam int NREG = 2 ** AW;
   localparam logic [AW:0] LAST_IDX = (AW + 1)'(NREG - 1);

   typedef enum logic {S_CLEAR, S_RUN} state_e;

   state_e          state_q, state_d;
   logic [AW:0]     idx_q, idx_d;
   logic [NREG-1:0] pending_q, pending_d;
   logic [XLEN-1:0] ram_q [NREG];

   logic            ram_we;
   logic [AW-1:0]   ram_wa;
   logic [XLEN-1:0] ram_wd;

   // Next state, scoreboard update and the single array write port (clear or writeback).
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      ram_we    = 1'b0;
      ram_wa    = '0;
      ram_wd    = '0;
      ready     = 1'b0;
      case (state_q)
         S_CLEAR: begin
            ram_we = 1'b1;
            ram_wa = idx_q[AW-1:0];
            idx_d  = idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_d = S_RUN;
         end
         S_RUN: begin
            ready = 1'b1;
            if (write && write_add != '0) begin
               ram_we               = 1'b1;
               ram_wa               = write_add;
               ram_wd               = data_received;
               pending_d[write_add] = 1'b0;
            end
            // Applied after the release so an issue to the same register wins.
            if (issue && issue_add != '0) pending_d[issue_add] = 1'b1;
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_CLEAR;
         idx_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
      end
   end

   // NOTE: the array has no reset term; the clear sequence zeroes it, keeping it mappable to RAM.
   always_ff @(posedge clk) begin
      if (!rst && ram_we) ram_q[ram_wa] <= ram_wd;
   end

   logic [AW-1:0]   rd_add  [2];
   logic [XLEN-1:0] rd_data [2];
   logic            rd_busy [2];

   assign rd_add[0] = src_add1;
   assign rd_add[1] = src_add2;

   // Read ports: x0 and CLEAR read as zero; a matching writeback bypasses the array and
   // releases busy unless a matching issue re-marks it in the same cycle.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         rd_busy[p] = 1'b0;
         if (state_q == S_RUN && rd_add[p] != '0) begin
            rd_data[p] = (write && write_add == rd_add[p]) ? data_received : ram_q[rd_add[p]];
            rd_busy[p] = pending_q[rd_add[p]] &&
                         !(write && write_add == rd_add[p] && !(issue && issue_add == rd_add[p]));
         end
      end
   end

   assign datasent1 = rd_data[0];
   assign datasent2 = rd_data[1];
   assign busy1     = rd_busy[0];
   assign busy2     = rd_busy[1];

endmodule
